// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver with 16x oversampling, one-byte holding register, valid/ack handshake.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches.
module uart_rx_deframer #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_parity_err
);

  localparam int TICK_DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t             r_state;
  logic [1:0]         r_sync;
  logic [DIV_W-1:0]   r_div;
  logic [3:0]         r_tcnt;
  logic [2:0]         r_bitcnt;
  logic [7:0]         r_shift;
  logic               r_dlv;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_ferr;
  logic               r_ovr;
`ifdef UART_RX_PARITY_EN
  logic               r_perr;
  logic               r_par_bad;
`endif

  logic w_rx_s;
  logic w_tick;

  assign w_rx_s = r_sync[1];
  assign w_tick = (r_state != S_IDLE) && (r_div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge sysclk) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], uart_rx};
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_tcnt    <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_dlv     <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_dlv <= 1'b0;

      // Divider idles at zero so a new frame always starts on a fresh tick phase
      if (r_state == S_IDLE || w_tick) r_div <= '0;
      else                             r_div <= r_div + 1'b1;

      if (r_dlv) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_perr  <= r_par_bad;
`endif
        if (r_valid && !rx_ack) r_ovr <= 1'b1;
        else if (r_valid)       r_ovr <= 1'b0;
      end else if (rx_ack && r_valid) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
        r_ferr  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_tcnt  <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_tcnt == 4'd7) begin
              if (w_rx_s) begin
                r_state <= S_IDLE;
              end else begin
                r_tcnt   <= '0;
                r_bitcnt <= '0;
                r_state  <= S_DATA;
              end
            end else begin
              r_tcnt <= r_tcnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_tcnt <= r_tcnt + 4'd1;
            if (r_tcnt == 4'd15) begin
              r_shift[r_bitcnt] <= w_rx_s;
              r_bitcnt          <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_tcnt <= r_tcnt + 4'd1;
            if (r_tcnt == 4'd15) begin
              r_par_bad <= w_rx_s ^ (^r_shift);
              r_state   <= S_STOP;
            end
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            r_tcnt <= r_tcnt + 4'd1;
            if (r_tcnt == 4'd15) begin
              if (w_rx_s) begin
                r_dlv   <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= S_BREAK;
              end
            end
          end
        end
        S_BREAK: begin
          // A held-low line must not retrigger frames until it returns high
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_busy      = (r_state != S_IDLE);
  assign rx_frame_err = r_ferr;
  assign rx_overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = r_perr;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: frame-level reference model compared every cycle, plus directed literal checks.
module tb_uart_rx_deframer;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 25_000;
  localparam int TD       = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int BIT      = 16 * TD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int LAT = 168 * TD + 3;
`else
  localparam bit PAR = 1'b0;
  localparam int LAT = 152 * TD + 3;
`endif

  logic       sysclk, reset, uart_rx, rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_parity_err;

  uart_rx_deframer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .sysclk(sysclk), .reset(reset), .uart_rx(uart_rx), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int n_vec = 0, n_err = 0, cyc = 0;
  int t0 = 0, t_rise = -1;
  logic pv = 1'b0;
  bit chk_en = 1'b0;

  // Reference model of the register-visible state
  logic       m_valid = 0, m_ovr = 0, m_ferr = 0, m_perr = 0;
  logic [7:0] m_data = 0;

  // One outstanding frame outcome, due near ev_cyc
  bit         ev_pending = 0, ev_ok = 0, ev_perr = 0;
  int         ev_cyc = 0;
  logic [7:0] ev_data = 0;

  initial forever begin
    @(posedge sysclk); #2;
    cyc = cyc + 1;
    if (rx_valid === 1'b1 && pv !== 1'b1) t_rise = cyc;
    pv = rx_valid;
    if (ev_pending && cyc >= ev_cyc + TD + 2) begin
      if (ev_ok) begin
        if (m_valid) m_ovr = 1'b1;
        m_data  = ev_data;
        m_valid = 1'b1;
        m_ferr  = 1'b0;
        m_perr  = ev_perr;
      end else begin
        m_ferr = 1'b1;
      end
      ev_pending = 0;
    end
    if (chk_en && !(ev_pending && cyc >= ev_cyc - TD - 2)) begin
      n_vec++;
      if ({rx_valid, rx_data, rx_overrun, rx_frame_err, rx_parity_err} !==
          {m_valid, m_data, m_ovr, m_ferr, m_perr}) begin
        n_err++;
        $display("FAIL model cyc=%0d got v=%b d=%02h ov=%b fe=%b pe=%b want v=%b d=%02h ov=%b fe=%b pe=%b",
                 cyc, rx_valid, rx_data, rx_overrun, rx_frame_err, rx_parity_err,
                 m_valid, m_data, m_ovr, m_ferr, m_perr);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    reset = 1'b1;
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_perr = 0; m_data = 0;
    ev_pending = 0;
    @(negedge sysclk);
    reset = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge sysclk);
    rx_ack = 1'b1;
    if (m_valid) begin m_valid = 0; m_ovr = 0; m_ferr = 0; end
    @(negedge sysclk);
    rx_ack = 1'b0;
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * BIT) @(negedge sysclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_bad, input int abort_bit);
    @(negedge sysclk);
    t0 = cyc;
    ev_data = d; ev_ok = stop; ev_perr = PAR && par_bad; ev_cyc = cyc + LAT; ev_pending = 1;
    uart_rx = 1'b0;
    repeat (BIT) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      if (i == abort_bit) begin
        repeat (BIT / 2) @(negedge sysclk);
        do_reset();
        uart_rx = 1'b1;
        return;
      end
      repeat (BIT) @(negedge sysclk);
    end
    if (PAR) begin
      uart_rx = (^d) ^ par_bad;
      repeat (BIT) @(negedge sysclk);
    end
    uart_rx = stop;
    repeat (BIT) @(negedge sysclk);
    if (stop) uart_rx = 1'b1;
  endtask

  initial begin
    int k, lat;
    logic [7:0] d;
    bit st, pb;
    uart_rx = 1'b1; rx_ack = 1'b0; reset = 1'b1;
    @(negedge sysclk); @(negedge sysclk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_data", rx_data, 8'h00);
    chk("reset_flags", {rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_parity_err}, 5'b0);
    idle_bits(1);

    // Single byte and latency
    send_frame(8'h0F, 1, 0, -1);
    idle_bits(1);
    chk("b0F_data", rx_data, 8'h0F);
    chk("b0F_flags", {rx_valid, rx_frame_err, rx_overrun, rx_parity_err}, 4'b1000);
    lat = t_rise - t0;
    chk("b0F_latency_ok", (lat >= LAT - TD && lat <= LAT + TD) ? 1 : 0, 1);

    // Back-to-back without ack gives overrun
    idle_bits(10);
    send_frame(8'hF0, 1, 0, -1);
    idle_bits(1);
    chk("ovr_data", rx_data, 8'hF0);
    chk("ovr_flags", {rx_valid, rx_overrun}, 2'b11);
    do_ack();
    chk("ack_flags", {rx_valid, rx_overrun}, 2'b00);
    chk("ack_keeps_data", rx_data, 8'hF0);

    // Glitch rejection
    @(negedge sysclk);
    uart_rx = 1'b0;
    repeat (10) @(negedge sysclk);
    chk("glitch_busy", rx_busy, 1'b1);
    uart_rx = 1'b1;
    k = 0;
    while (rx_busy === 1'b1 && k < BIT) begin @(negedge sysclk); k++; end
    chk("glitch_idle", rx_busy, 1'b0);
    chk("glitch_flags", {rx_valid, rx_frame_err}, 2'b00);
    idle_bits(1);

    // Framing error then a good frame
    send_frame(8'h55, 0, 0, -1);
    repeat (2 * BIT) @(negedge sysclk);
    chk("ferr_flags", {rx_valid, rx_frame_err}, 2'b01);
    chk("ferr_busy_break", rx_busy, 1'b1);
    idle_bits(2);
    chk("ferr_single", {rx_busy, rx_frame_err}, 2'b01);
    send_frame(8'hA5, 1, 0, -1);
    idle_bits(1);
    chk("ferr_next_data", rx_data, 8'hA5);
    chk("ferr_next_flags", {rx_valid, rx_frame_err}, 2'b10);
    do_ack();

    // Reset during data bit 4
    send_frame(8'h3C, 1, 0, 4);
    chk("rst_mid_data", rx_data, 8'h00);
    chk("rst_mid_flags", {rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_parity_err}, 5'b0);
    idle_bits(12);
    chk("rst_no_partial", rx_valid, 1'b0);
    send_frame(8'h3C, 1, 0, -1);
    idle_bits(1);
    chk("rst_next_data", rx_data, 8'h3C);
    chk("rst_next_valid", rx_valid, 1'b1);
    do_ack();

    // Wrong parity bit (no parity bit at all in 8N1 builds)
    send_frame(8'h07, 1, 1, -1);
    idle_bits(1);
    chk("par_data", rx_data, 8'h07);
    chk("par_flags", {rx_valid, rx_parity_err}, {1'b1, PAR});
    do_ack();
    idle_bits(1);

    // Randomized frames against the model
    repeat (30) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      pb = ($urandom_range(0, 3) == 0);
      send_frame(d, st, pb, -1);
      if (!st) repeat (BIT) @(negedge sysclk);
      idle_bits($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) do_ack();
    end
    idle_bits(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
